// File: rtl/rr_arbiter8.sv
// Eight-input round-robin arbiter with a bounded hold time.
// One requester owns the grant at a time. The owner is released when it
// signals done, when it drops its request, or when it has held the grant for
// MAX_HOLD cycles, in which case a one-cycle timeout pulse is raised.
// Every release is followed by at least one idle cycle before the next grant.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_OWNED = 1'b1;

  logic       state;
  logic [2:0] last;
  logic [7:0] hold_cnt;

  logic [2:0]  search_start;
  logic [15:0] req_doubled;
  logic [7:0]  req_rotated;
  logic [2:0]  win_offset;
  logic        win_found;
  logic [2:0]  win_idx;

  logic owner_req;
  logic hold_limit;
  logic release_now;

  // Rotate the request vector so the search begins just after the last
  // winner, pick the lowest set bit, then map the offset back to an index.
  always_comb begin
    search_start = last + 3'd1;
    req_doubled  = {req, req} >> search_start;
    req_rotated  = req_doubled[7:0];
    win_offset   = 3'd0;
    win_found    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!win_found && req_rotated[i]) begin
        win_found  = 1'b1;
        win_offset = 3'(i);
      end
    end
    win_idx = search_start + win_offset;
  end

  // Release conditions evaluated against the current owner.
  always_comb begin
    owner_req   = req[grant_id];
    hold_limit  = (hold_cnt == 8'(MAX_HOLD));
    release_now = done || !owner_req || hold_limit;
  end

  // Ownership FSM: issue grants from IDLE, release from OWNED; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= STATE_IDLE;
      grant       <= 8'd0;
      grant_id    <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= 8'd0;
      last        <= 3'd7;
    end else begin
      case (state)
        STATE_IDLE: begin
          timeout <= 1'b0;
          if (win_found) begin
            state       <= STATE_OWNED;
            grant       <= 8'd1 << win_idx;
            grant_id    <= win_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= 8'd1;
            last        <= win_idx;
          end
        end
        default: begin
          if (release_now) begin
            state       <= STATE_IDLE;
            grant       <= 8'd0;
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            hold_cnt    <= 8'd0;
            timeout     <= hold_limit && !done && owner_req;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
            timeout  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 (hold limit set to 4).
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int checks;
  int failures;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, let one rising edge pass, then settle 1 ns before checks.
  task automatic applyStimulus(input logic r, input logic [7:0] q, input logic d);
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] g, input logic [2:0] id,
                          input logic v, input logic t);
    checkOutput({tag, ".grant"}, grant, g);
    checkOutput({tag, ".grant_id"}, 8'(grant_id), 8'(id));
    checkOutput({tag, ".valid"}, 8'(grant_valid), 8'(v));
    checkOutput({tag, ".timeout"}, 8'(timeout), 8'(t));
  endtask

  // Grant edge with requests already held, then a done pulse releasing it.
  task automatic grantThenDone(input string tag, input logic [7:0] q, input logic [2:0] id);
    applyStimulus(1'b0, q, 1'b0);
    checkAll({tag, ".grant"}, 8'd1 << id, id, 1'b1, 1'b0);
    applyStimulus(1'b0, q, 1'b1);
    checkAll({tag, ".release"}, 8'd0, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    req  = 8'd0;
    done = 1'b0;

    // Reset state
    applyStimulus(1'b1, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'd0, 1'b0);
    checkAll("reset", 8'd0, 3'd0, 1'b0, 1'b0);

    // done in IDLE is ignored
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkAll("idle_done", 8'd0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkAll("idle_done2", 8'd0, 3'd0, 1'b0, 1'b0);

    // Two requesters alternate 0,7,0,7
    grantThenDone("alt0", 8'h81, 3'd0);
    grantThenDone("alt1", 8'h81, 3'd7);
    grantThenDone("alt2", 8'h81, 3'd0);
    grantThenDone("alt3", 8'h81, 3'd7);

    // All requesting: 0..7 then wrap to 0
    applyStimulus(1'b1, 8'd0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      grantThenDone($sformatf("all%0d", i), 8'hFF, 3'(i % 8));
    end

    // Hold limit: 4 cycles of grant, timeout pulse, then re-grant
    applyStimulus(1'b1, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'h04, 1'b0);
    checkAll("hold.c1", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b0, 8'h04, 1'b0);
      checkAll($sformatf("hold.c%0d", i), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 8'h04, 1'b0);
    checkAll("hold.timeout", 8'd0, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h04, 1'b0);
    checkAll("hold.regrant", 8'h04, 3'd2, 1'b1, 1'b0);
    // done at the limit edge suppresses timeout
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b0, 8'h04, 1'b0);
    end
    applyStimulus(1'b0, 8'h04, 1'b1);
    checkAll("hold.done_suppress", 8'd0, 3'd0, 1'b0, 1'b0);

    // Owner drops request; non-owner changes do not disturb the grant
    applyStimulus(1'b1, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'h28, 1'b0);
    checkAll("drop.grant3", 8'h08, 3'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'hA9, 1'b0);
    checkAll("drop.other_change", 8'h08, 3'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h20, 1'b0);
    checkAll("drop.release", 8'd0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h20, 1'b0);
    checkAll("drop.grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkAll("drop.release5", 8'd0, 3'd0, 1'b0, 1'b0);

    // Reset mid-grant, then arbitration restarts from index 0
    applyStimulus(1'b1, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'h40, 1'b0);
    checkAll("rst.grant6", 8'h40, 3'd6, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkAll("rst.drop", 8'd0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'hFF, 1'b0);
    checkAll("rst.resume", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 15: maximum consecutive cycles one owner may hold a grant (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req  input  8  request vector, bit i = requester i.
REQ-005 The block SHALL have port done  input  1  owner release strobe, sampled only while grant_valid=1.
REQ-006 The block SHALL have port grant  output  8  one-hot grant vector, registered.
REQ-007 The block SHALL have port grant_id  output  3  binary index of the granted requester, registered.
REQ-008 The block SHALL have port grant_valid  output  1  high while any grant is active, registered.
REQ-009 The block SHALL have port timeout  output  1  one-cycle pulse marking a forced release, registered.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and OWNED (one grant active).
REQ-011 In IDLE with req != 0 at edge N, the block SHALL enter OWNED and assert grant/grant_id/grant_valid from edge N, visible in cycle N+1; with req == 0 it SHALL stay in IDLE.
REQ-012 Winner selection SHALL be round-robin: search indices last+1, last+2, ... mod 8; the first set req bit wins; last = index of the most recent grant.
REQ-013 Selection SHALL be combinational priority encoding over the rotated req vector; the result SHALL be rotated back to an absolute index (3-bit wrap-around, 7+1=0).
REQ-014 last SHALL update to the winner index on the edge the grant is issued.
REQ-015 In OWNED, grant SHALL have exactly one bit set, equal to 1<<grant_id; in IDLE grant=0, grant_id=0, grant_valid=0.
REQ-016 In OWNED, the block SHALL release (return to IDLE, clear grant on that edge) when any of these holds: done=1; req[grant_id]=0; hold counter reaches MAX_HOLD.
REQ-017 The hold counter (8 bits) SHALL load 1 on grant issue and increment each OWNED cycle without release; the release condition is counter == MAX_HOLD at the sampling edge.
REQ-018 timeout SHALL pulse high for exactly one cycle after a release caused only by the hold limit; done=1 or a dropped req in the same cycle SHALL suppress timeout.
REQ-019 Every release SHALL be followed by at least one IDLE cycle (grant_valid=0) before the next grant; back-to-back grants without a gap are forbidden.
REQ-020 req changes on non-owner bits during OWNED SHALL NOT affect the current grant.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 With MAX_HOLD=1, each grant SHALL last exactly one cycle and always raise timeout unless done or a dropped req also releases in that cycle.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, grant=0, grant_id=0, grant_valid=0, timeout=0, hold counter=0, last=7 (first search starts at index 0).
REQ-024 rst SHALL take priority over every other input, including mid-grant; the grant SHALL drop on the first edge with rst=1.
REQ-025 After rst deasserts, arbitration SHALL resume per REQ-011 on the next edge.

Verification
REQ-026 After reset, hold req=8'b1000_0001, pulse done each grant -> grant_id sequence 0,7,0,7 with a one-cycle gap between grants.
REQ-027 After reset, hold req=8'hFF, pulse done one cycle after each grant -> grant_id sequence 0,1,2,...,7,0 (wrap-around).
REQ-028 MAX_HOLD=4, req=8'h04 held, done=0 -> grant=8'h04 for 4 cycles, then grant=0 and timeout=1 for one cycle, then re-grant to 2.
REQ-029 Granted requester 3, drop req[3] while req[5]=1 -> grant clears on next edge, timeout=0, one idle cycle, then grant_id=5.
REQ-030 Assert rst during an active grant to requester 6 -> all outputs 0 on the next edge; with req=8'hFF after release, first grant_id=0.
REQ-031 Drive done=1 in IDLE with req=0 -> no state change; all outputs remain 0.
